// File: rtl/banner_pkg.sv
// Shared definitions for the banner sequencer and the banner renderer:
// game-phase encoding, banner image indices and a constant-sizing helper.
package banner_pkg;

   // Top-level game phases.
   typedef enum logic [2:0] {
      INIT  = 3'd0,
      REGEN = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } banner_state_t;

   // Banner image indices; the renderer uses the same numbering.
   localparam int BANNER_INIT  = 0;
   localparam int BANNER_PAUSE = 1;
   localparam int BANNER_OVER  = 2;
   localparam int BANNER_REGEN = 3;

   // Largest of three values; sizes the shared frame counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/banner_controller_frame_timer.sv
// Saturating frame counter. A synchronous clear takes priority over a
// frame tick arriving in the same cycle.
module frame_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick,
   output logic [WIDTH-1:0] count
);

   // Count frame ticks, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/banner_controller.sv
// Game-mode sequencer for the banner overlay. Tracks the game phase,
// drives the banner index / overlay enable / gameplay enable, and owns
// the request/done handshake with the level generator. All outputs are
// registered from the next-state decode so they change only on clock
// edges or reset.
module banner_controller
   import banner_pkg::*;
#(
   parameter int NUM_IMAGES       = 4,
   parameter int GAME_OVER_FRAMES = 180,
   parameter int REGEN_MIN_FRAMES = 30,
   parameter int BLINK_FRAMES     = 30
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_frame_tick,
   input  logic                          i_btn_start,
   input  logic                          i_btn_pause,
   input  logic                          i_game_over,
   input  logic                          i_regen_done,
   output logic                          o_regen_req,
   output logic [$clog2(NUM_IMAGES)-1:0] o_banner_num,
   output logic                          o_banner_enbl,
   output logic                          o_game_run
);

   localparam int BANNER_W = $clog2(NUM_IMAGES);
   localparam int CNT_MAX  = max3(GAME_OVER_FRAMES, REGEN_MIN_FRAMES, 2 * BLINK_FRAMES);
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] OVER_HOLD  = CNT_W'(GAME_OVER_FRAMES);
   localparam logic [CNT_W-1:0] REGEN_HOLD = CNT_W'(REGEN_MIN_FRAMES);
   // Last count of the visible half and of the full blink period.
   localparam logic [CNT_W-1:0] BLINK_OFF  = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] BLINK_WRAP = CNT_W'(2 * BLINK_FRAMES - 1);

   banner_state_t    state;
   banner_state_t    next_state;
   logic [CNT_W-1:0] frame_cnt;
   logic             cnt_clr;
   logic             pause_wrap;
   logic             blink_next;
   logic             req_next;
   logic             done_next;
   logic             done_seen;

   frame_timer #(
      .WIDTH (CNT_W)
   ) u_frame_timer (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (cnt_clr),
      .tick  (i_frame_tick),
      .count (frame_cnt)
   );

   // Next-phase decode; inputs that do not apply to the current phase are ignored.
   always_comb begin
      next_state = state;
      case (state)
         INIT: begin
            if (i_btn_start) begin
               next_state = REGEN;
            end else begin
               next_state = INIT;
            end
         end
         REGEN: begin
            if (done_seen && (frame_cnt >= REGEN_HOLD)) begin
               next_state = PLAY;
            end else begin
               next_state = REGEN;
            end
         end
         PLAY: begin
            // Game over wins over a pause arriving in the same cycle.
            if (i_game_over) begin
               next_state = OVER;
            end else if (i_btn_pause) begin
               next_state = PAUSE;
            end else begin
               next_state = PLAY;
            end
         end
         PAUSE: begin
            if (i_btn_pause || i_btn_start) begin
               next_state = PLAY;
            end else begin
               next_state = PAUSE;
            end
         end
         OVER: begin
            if (i_btn_start && (frame_cnt >= OVER_HOLD)) begin
               next_state = REGEN;
            end else begin
               next_state = OVER;
            end
         end
         default: begin
            next_state = INIT;
         end
      endcase
   end

   // Counter clear, pause-blink phase and handshake bookkeeping for the next cycle.
   always_comb begin
      pause_wrap = (state == PAUSE) && i_frame_tick && (frame_cnt == BLINK_WRAP);
      cnt_clr    = (next_state != state) || pause_wrap;

      // Blink starts visible on entry, hides after BLINK_FRAMES ticks, reappears on wrap.
      if (state != PAUSE) begin
         blink_next = 1'b1;
      end else if (pause_wrap) begin
         blink_next = 1'b1;
      end else if (i_frame_tick && (frame_cnt == BLINK_OFF)) begin
         blink_next = 1'b0;
      end else begin
         blink_next = o_banner_enbl;
      end

      // Request rises on REGEN entry and drops on the edge that samples done.
      if (next_state != REGEN) begin
         req_next = 1'b0;
      end else if (state != REGEN) begin
         req_next = 1'b1;
      end else if (i_regen_done) begin
         req_next = 1'b0;
      end else begin
         req_next = o_regen_req;
      end

      // Sticky done flag, only live while staying in REGEN; entry clears it.
      if ((state == REGEN) && (next_state == REGEN)) begin
         done_next = done_seen | i_regen_done;
      end else begin
         done_next = 1'b0;
      end
   end

   // Phase register and Moore outputs registered from the next phase.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= INIT;
         done_seen     <= 1'b0;
         o_regen_req   <= 1'b0;
         o_banner_num  <= BANNER_W'(BANNER_INIT);
         o_banner_enbl <= 1'b1;
         o_game_run    <= 1'b0;
      end else begin
         state       <= next_state;
         done_seen   <= done_next;
         o_regen_req <= req_next;
         case (next_state)
            INIT: begin
               o_banner_num  <= BANNER_W'(BANNER_INIT);
               o_banner_enbl <= 1'b1;
               o_game_run    <= 1'b0;
            end
            REGEN: begin
               o_banner_num  <= BANNER_W'(BANNER_REGEN);
               o_banner_enbl <= 1'b1;
               o_game_run    <= 1'b0;
            end
            PLAY: begin
               o_banner_num  <= BANNER_W'(BANNER_INIT);
               o_banner_enbl <= 1'b0;
               o_game_run    <= 1'b1;
            end
            PAUSE: begin
               o_banner_num  <= BANNER_W'(BANNER_PAUSE);
               o_banner_enbl <= blink_next;
               o_game_run    <= 1'b0;
            end
            OVER: begin
               o_banner_num  <= BANNER_W'(BANNER_OVER);
               o_banner_enbl <= 1'b1;
               o_game_run    <= 1'b0;
            end
            default: begin
               o_banner_num  <= BANNER_W'(BANNER_INIT);
               o_banner_enbl <= 1'b1;
               o_game_run    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_banner_controller.sv
// Self-checking bench for banner_controller with short frame parameters.
// Each stimulus cycle pushes its expected outputs to a scoreboard queue;
// the entry is popped and compared just after the clock edge.
module tb_banner_controller;

   logic       i_clk;
   logic       i_rst;
   logic       i_frame_tick;
   logic       i_btn_start;
   logic       i_btn_pause;
   logic       i_game_over;
   logic       i_regen_done;
   logic       o_regen_req;
   logic [1:0] o_banner_num;
   logic       o_banner_enbl;
   logic       o_game_run;

   int checks = 0;
   int errors = 0;

   string      tag_q[$];
   logic [4:0] exp_q[$];

   banner_controller #(
      .NUM_IMAGES       (4),
      .GAME_OVER_FRAMES (4),
      .REGEN_MIN_FRAMES (2),
      .BLINK_FRAMES     (2)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_frame_tick  (i_frame_tick),
      .i_btn_start   (i_btn_start),
      .i_btn_pause   (i_btn_pause),
      .i_game_over   (i_game_over),
      .i_regen_done  (i_regen_done),
      .o_regen_req   (o_regen_req),
      .o_banner_num  (o_banner_num),
      .o_banner_enbl (o_banner_enbl),
      .o_game_run    (o_game_run)
   );

   // 10-unit clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic push_exp(input string tag, input logic [1:0] num, input logic enbl,
                           input logic run, input logic req);
      tag_q.push_back(tag);
      exp_q.push_back({num, enbl, run, req});
   endtask

   task automatic compare_out();
      string      t;
      logic [4:0] e;
      if (exp_q.size() == 0) begin
         check_val("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check_val({t, ".num"},  32'(o_banner_num),  32'(e[4:3]));
         check_val({t, ".enbl"}, 32'(o_banner_enbl), 32'(e[2]));
         check_val({t, ".run"},  32'(o_game_run),    32'(e[1]));
         check_val({t, ".req"},  32'(o_regen_req),   32'(e[0]));
      end
   endtask

   // Drive one cycle of pulses, expect the given outputs after the edge.
   task automatic run_cycle(input string tag, input logic s, input logic p, input logic g,
                            input logic d, input logic t, input logic [1:0] num,
                            input logic enbl, input logic run, input logic req);
      push_exp(tag, num, enbl, run, req);
      i_btn_start  = s;
      i_btn_pause  = p;
      i_game_over  = g;
      i_regen_done = d;
      i_frame_tick = t;
      @(posedge i_clk);
      #1;
      i_btn_start  = 1'b0;
      i_btn_pause  = 1'b0;
      i_game_over  = 1'b0;
      i_regen_done = 1'b0;
      i_frame_tick = 1'b0;
      compare_out();
   endtask

   initial begin
      i_rst        = 1'b1;
      i_frame_tick = 1'b0;
      i_btn_start  = 1'b0;
      i_btn_pause  = 1'b0;
      i_game_over  = 1'b0;
      i_regen_done = 1'b0;
      repeat (2) @(posedge i_clk);
      #2;
      i_rst = 1'b0;
      #1;
      push_exp("reset", 2'd0, 1'b1, 1'b0, 1'b0);
      compare_out();

      // Reset to play                  s  p  g  d  t   num  en  run req
      run_cycle("init_idle",           0, 0, 0, 0, 0, 2'd0, 1, 0, 0);
      run_cycle("init_pause_ignored",  0, 1, 0, 0, 0, 2'd0, 1, 0, 0);
      run_cycle("regen_entry",         1, 0, 0, 0, 0, 2'd3, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         run_cycle("regen_frames",     0, 0, 0, 0, 1, 2'd3, 1, 0, 1);
      end
      run_cycle("regen_done_drop",     0, 0, 0, 1, 0, 2'd3, 1, 0, 0);
      run_cycle("play_entry",          0, 0, 0, 0, 0, 2'd0, 0, 1, 0);
      run_cycle("play_done_ignored",   0, 0, 0, 1, 0, 2'd0, 0, 1, 0);
      run_cycle("play_start_ignored",  1, 0, 0, 0, 0, 2'd0, 0, 1, 0);

      // Pause blink
      run_cycle("pause_entry",         0, 1, 0, 0, 0, 2'd1, 1, 0, 0);
      run_cycle("blink_t1",            0, 0, 0, 0, 1, 2'd1, 1, 0, 0);
      run_cycle("blink_t2",            0, 0, 0, 0, 1, 2'd1, 0, 0, 0);
      run_cycle("blink_hold",          0, 0, 0, 0, 0, 2'd1, 0, 0, 0);
      run_cycle("blink_t3",            0, 0, 0, 0, 1, 2'd1, 0, 0, 0);
      run_cycle("blink_wrap",          0, 0, 0, 0, 1, 2'd1, 1, 0, 0);
      run_cycle("blink_t5",            0, 0, 0, 0, 1, 2'd1, 1, 0, 0);
      run_cycle("blink_t6",            0, 0, 0, 0, 1, 2'd1, 0, 0, 0);
      run_cycle("pause_over_ignored",  0, 0, 1, 0, 0, 2'd1, 0, 0, 0);
      run_cycle("pause_exit",          0, 1, 0, 0, 0, 2'd0, 0, 1, 0);
      run_cycle("pause_again",         0, 1, 0, 0, 0, 2'd1, 1, 0, 0);
      run_cycle("pause_start_exit",    1, 0, 0, 0, 0, 2'd0, 0, 1, 0);

      // Game-over gating
      run_cycle("over_entry",          0, 0, 1, 0, 0, 2'd2, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         run_cycle("over_frames",      0, 0, 0, 0, 1, 2'd2, 1, 0, 0);
      end
      run_cycle("over_start_gated",    1, 0, 0, 0, 0, 2'd2, 1, 0, 0);
      run_cycle("over_pause_ignored",  0, 1, 0, 0, 0, 2'd2, 1, 0, 0);
      run_cycle("over_frame4",         0, 0, 0, 0, 1, 2'd2, 1, 0, 0);
      // Done on the entry cycle is not seen: request stays high afterwards.
      run_cycle("over_to_regen",       1, 0, 0, 1, 0, 2'd3, 1, 0, 1);
      run_cycle("entry_done_unseen",   0, 0, 0, 0, 0, 2'd3, 1, 0, 1);

      // Regeneration hold
      run_cycle("hold_req_drop",       0, 0, 0, 1, 0, 2'd3, 1, 0, 0);
      run_cycle("hold_idle",           0, 0, 0, 0, 0, 2'd3, 1, 0, 0);
      run_cycle("hold_t1",             0, 0, 0, 0, 1, 2'd3, 1, 0, 0);
      run_cycle("hold_t2",             0, 0, 0, 0, 1, 2'd3, 1, 0, 0);
      run_cycle("hold_exit",           0, 0, 0, 0, 0, 2'd0, 0, 1, 0);

      // Simultaneous events; tick on the OVER entry edge must not count
      run_cycle("simul_over",          0, 1, 1, 0, 1, 2'd2, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         run_cycle("simul_frames",     0, 0, 0, 0, 1, 2'd2, 1, 0, 0);
      end
      run_cycle("simul_cnt_zero",      1, 0, 0, 0, 0, 2'd2, 1, 0, 0);
      run_cycle("simul_frame4",        0, 0, 0, 0, 1, 2'd2, 1, 0, 0);
      run_cycle("simul_to_regen",      1, 0, 0, 0, 0, 2'd3, 1, 0, 1);

      // Reset mid-operation: asynchronous, between clock edges
      #2;
      i_rst = 1'b1;
      #1;
      push_exp("async_rst", 2'd0, 1'b1, 1'b0, 1'b0);
      compare_out();
      @(posedge i_clk);
      #1;
      push_exp("rst_held", 2'd0, 1'b1, 1'b0, 1'b0);
      compare_out();
      i_rst = 1'b0;
      run_cycle("post_rst_idle",       0, 0, 0, 0, 0, 2'd0, 1, 0, 0);
      run_cycle("post_rst_regen",      1, 0, 0, 0, 0, 2'd3, 1, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
